// File: rtl/sw_ctrl.sv
// sw_ctrl: run/pause/clear/lap controller for the MM:SS stopwatch.
// Debounces the start/stop, clear and lap keys on the key-filter strobe,
// sequences the stopwatch FSM, gates the 1 s pulse into counter stage 0,
// issues the soft-reset pulse and selects live or lap digits for display.
// Optional feature macro: SW_CTRL_LAP_EN (lap state, lap register, key_lap).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | stopped, counters cleared or awaiting first start
// RUN   | counting, display follows live digits
// PAUSE | counting held, display follows live digits
// LAP   | counting continues, display frozen on the lap register
module sw_ctrl #(
   parameter int DEB_CNT    = 3,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_smp,
   input  logic                  pps,
   input  logic                  key_ss,
   input  logic                  key_clr,
   input  logic                  key_lap,
   input  logic [DATA_WIDTH-1:0] live_data,
   output logic                  pulse_cnt,
   output logic                  sft_rst,
   output logic [DATA_WIDTH-1:0] disp_data,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_t;

   localparam logic [3:0] DEB_LOAD = 4'(DEB_CNT - 1);

   // key index: 0 = start/stop, 1 = clear, 2 = lap
   logic [2:0]      key_raw;
   logic [2:0]      stable_q, stable_d;
   logic [2:0][3:0] deb_cnt_q, deb_cnt_d;
   logic [2:0]      key_ev;
   logic            ev_clr, ev_ss, ev_lap;

   state_t                  state_q, state_d;
   logic                    pulse_cnt_q, pulse_cnt_d;
   logic                    sft_rst_q, sft_rst_d;
   logic [DATA_WIDTH-1:0]   disp_data_q, disp_data_d;
`ifdef SW_CTRL_LAP_EN
   logic                    lap_latch;
   logic [DATA_WIDTH-1:0]   lap_q, lap_d;
`endif

   assign key_raw = {key_lap, key_clr, key_ss};

   // Debounce: the down-counter holds the samples still needed before the
   // differing level is accepted; zero means no change is in progress.
   always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = deb_cnt_q;
      key_ev    = '0;
      if (key_smp) begin
         for (int k = 0; k < 3; k++) begin
            if (key_raw[k] == stable_q[k]) begin
               deb_cnt_d[k] = '0;
            end else if ((deb_cnt_q[k] == 4'd0 && DEB_LOAD == 4'd0) ||
                         deb_cnt_q[k] == 4'd1) begin
               stable_d[k]  = key_raw[k];
               deb_cnt_d[k] = '0;
               key_ev[k]    = key_raw[k];
            end else if (deb_cnt_q[k] == 4'd0) begin
               deb_cnt_d[k] = DEB_LOAD;
            end else begin
               deb_cnt_d[k] = deb_cnt_q[k] - 4'd1;
            end
         end
      end
   end

   // Same-cycle events resolve as clear > start/stop > lap.
   assign ev_clr = key_ev[1];
   assign ev_ss  = key_ev[0] & ~key_ev[1];
`ifdef SW_CTRL_LAP_EN
   assign ev_lap = key_ev[2] & ~key_ev[0] & ~key_ev[1];
`else
   assign ev_lap = 1'b0;
`endif

   // Next state, soft reset, count gating and display select.
   always_comb begin
      state_d   = state_q;
      sft_rst_d = 1'b0;
`ifdef SW_CTRL_LAP_EN
      lap_latch = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ev_clr)     sft_rst_d = 1'b1;
            else if (ev_ss) state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (ev_ss) begin
               state_d = ST_PAUSE;
            end else if (ev_lap) begin
               state_d = ST_LAP;
`ifdef SW_CTRL_LAP_EN
               lap_latch = 1'b1;
`endif
            end
         end
         ST_PAUSE: begin
            if (ev_clr) begin
               state_d   = ST_IDLE;
               sft_rst_d = 1'b1;
            end else if (ev_ss) begin
               state_d = ST_RUN;
            end
         end
         ST_LAP: begin
`ifdef SW_CTRL_LAP_EN
            if (ev_ss)       state_d = ST_PAUSE;
            else if (ev_lap) state_d = ST_RUN;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      pulse_cnt_d = pps & ((state_q == ST_RUN) | (state_q == ST_LAP));

`ifdef SW_CTRL_LAP_EN
      lap_d       = lap_latch ? live_data : lap_q;
      disp_data_d = (state_d == ST_LAP) ? lap_d : live_data;
`else
      disp_data_d = live_data;
`endif
   end

   // Register all state; reset returns to IDLE with cleared debouncers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q    <= '0;
         deb_cnt_q   <= '0;
         state_q     <= ST_IDLE;
         pulse_cnt_q <= 1'b0;
         sft_rst_q   <= 1'b0;
         disp_data_q <= '0;
`ifdef SW_CTRL_LAP_EN
         lap_q       <= '0;
`endif
      end else begin
         stable_q    <= stable_d;
         deb_cnt_q   <= deb_cnt_d;
         state_q     <= state_d;
         pulse_cnt_q <= pulse_cnt_d;
         sft_rst_q   <= sft_rst_d;
         disp_data_q <= disp_data_d;
`ifdef SW_CTRL_LAP_EN
         lap_q       <= lap_d;
`endif
      end
   end

   assign pulse_cnt = pulse_cnt_q;
   assign sft_rst   = sft_rst_q;
   assign disp_data = disp_data_q;
   assign state     = state_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// Testbench for sw_ctrl: directed vector table, hand sequences for lap,
// async reset and held keys, then random stimulus against a reference model.
module tb_sw_ctrl;

   localparam int DEB = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_smp = 1'b0;
   logic        pps = 1'b0;
   logic        key_ss = 1'b0;
   logic        key_clr = 1'b0;
   logic        key_lap = 1'b0;
   logic [15:0] live_data = 16'h0000;
   logic        pulse_cnt;
   logic        sft_rst;
   logic [15:0] disp_data;
   logic [1:0]  state;

   sw_ctrl #(.DEB_CNT(DEB), .DATA_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_smp   (key_smp),
      .pps       (pps),
      .key_ss    (key_ss),
      .key_clr   (key_clr),
      .key_lap   (key_lap),
      .live_data (live_data),
      .pulse_cnt (pulse_cnt),
      .sft_rst   (sft_rst),
      .disp_data (disp_data),
      .state     (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a key level is accepted once the last DEB samples all
   // differ from the accepted level; transitions come from a lookup table.
   logic [15:0] m_hist [3];
   int          m_nsmp [3];
   bit          m_stable [3];
   int          m_state;
   bit          m_pulse, m_sft;
   logic [15:0] m_disp, m_lap;
   int          nxt [4][3];   // [state][winner: 0 clr, 1 ss, 2 lap]

   typedef struct {
      logic        ss, clr, lap, smp, pps;
      logic [15:0] live;
      logic [1:0]  st;
      logic        pu, sr;
      logic [15:0] disp;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_hist[k] = '0; m_nsmp[k] = 0; m_stable[k] = 1'b0;
      end
      m_state = 0; m_pulse = 0; m_sft = 0; m_disp = '0; m_lap = '0;
   endtask

   task automatic model_step();
      bit          raw [3];
      bit          ev [3];
      logic [15:0] mask;
      int          win, old;
      raw[0] = key_ss; raw[1] = key_clr; raw[2] = key_lap;
      mask = 16'((1 << DEB) - 1);
      for (int k = 0; k < 3; k++) begin
         ev[k] = 1'b0;
         if (key_smp) begin
            m_hist[k] = {m_hist[k][14:0], raw[k]};
            if (m_nsmp[k] < 16) m_nsmp[k]++;
            if (m_nsmp[k] >= DEB &&
                (m_hist[k] & mask) == (m_stable[k] ? 16'h0000 : mask)) begin
               m_stable[k] = !m_stable[k];
               ev[k] = m_stable[k];
            end
         end
      end
      win = -1;
      if (ev[1])      win = 0;
      else if (ev[0]) win = 1;
`ifdef SW_CTRL_LAP_EN
      else if (ev[2]) win = 2;
`endif
      old     = m_state;
      m_pulse = pps && (old == 1 || old == 3);
      m_sft   = (win == 0) && (old == 0 || old == 2);
      if (win >= 0) m_state = nxt[old][win];
      if (old == 1 && m_state == 3) m_lap = live_data;
      m_disp = (m_state == 3) ? m_lap : live_data;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("model_state", 16'(state), 16'(m_state));
      chk("model_pulse", 16'(pulse_cnt), 16'(m_pulse));
      chk("model_sft", 16'(sft_rst), 16'(m_sft));
      chk("model_disp", disp_data, m_disp);
   endtask

   task automatic apply(input bit ss, input bit clr, input bit lap,
                        input bit smp, input bit p);
      key_ss = ss; key_clr = clr; key_lap = lap; key_smp = smp; pps = p;
      step();
   endtask

   task automatic hold(input bit ss, input bit clr, input bit lap, input int n);
      for (int i = 0; i < n; i++) apply(ss, clr, lap, 1'b1, 1'b0);
   endtask

   task automatic add(input bit ss, input bit clr, input bit lap, input bit smp,
                      input bit p, input logic [15:0] live, input logic [1:0] st,
                      input bit pu, input bit sr, input logic [15:0] disp);
      vec_t v;
      v.ss = ss; v.clr = clr; v.lap = lap; v.smp = smp; v.pps = p;
      v.live = live; v.st = st; v.pu = pu; v.sr = sr; v.disp = disp;
      tbl.push_back(v);
   endtask

   initial begin
      nxt[0][0] = 0; nxt[0][1] = 1; nxt[0][2] = 0;
      nxt[1][0] = 1; nxt[1][1] = 2; nxt[1][2] = 3;
      nxt[2][0] = 0; nxt[2][1] = 1; nxt[2][2] = 2;
      nxt[3][0] = 3; nxt[3][1] = 2; nxt[3][2] = 1;
      model_reset();

      //   ss clr lap smp pps  live      st  pu sr disp
      add(1, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 0, 16'h0000); // 0 ss sample 1
      add(1, 0, 0, 0, 0, 16'h0000, 2'd0, 0, 0, 16'h0000);
      add(1, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 0, 16'h0000);
      add(1, 0, 0, 1, 1, 16'h0000, 2'd1, 0, 0, 16'h0000); // 3 enter RUN, pps blocked
      add(1, 0, 0, 0, 1, 16'h0000, 2'd1, 1, 0, 16'h0000);
      add(0, 0, 0, 0, 0, 16'h0123, 2'd1, 0, 0, 16'h0123);
      add(0, 0, 0, 1, 0, 16'h0123, 2'd1, 0, 0, 16'h0123);
      add(0, 0, 0, 1, 1, 16'h0124, 2'd1, 1, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124); // 8 ss released
      add(1, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 1, 16'h0124, 2'd2, 1, 0, 16'h0124); // 11 leave RUN, pps passes
      add(1, 0, 0, 0, 1, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(1, 0, 0, 0, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 1, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 1, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 1, 0, 1, 0, 16'h0124, 2'd0, 0, 1, 16'h0124); // 19 clear from PAUSE
      add(0, 1, 0, 0, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd0, 0, 0, 16'h0124); // 21 bounce
      add(0, 0, 0, 1, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124); // 27 one transition
      add(1, 0, 0, 1, 1, 16'h0124, 2'd1, 1, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd1, 0, 0, 16'h0124);
      add(1, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124); // 34 PAUSE
      add(0, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(0, 0, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(1, 1, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124); // 38 clr+ss together
      add(1, 1, 0, 1, 0, 16'h0124, 2'd2, 0, 0, 16'h0124);
      add(1, 1, 0, 1, 0, 16'h0124, 2'd0, 0, 1, 16'h0124); // 40 clear wins
      add(0, 0, 0, 0, 0, 16'h0124, 2'd0, 0, 0, 16'h0124);

      // reset held for 5 cycles
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_state", 16'(state), 16'h0000);
      chk("rst_pulse", 16'(pulse_cnt), 16'h0000);
      chk("rst_sft", 16'(sft_rst), 16'h0000);
      chk("rst_disp", disp_data, 16'h0000);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         live_data = tbl[i].live;
         apply(tbl[i].ss, tbl[i].clr, tbl[i].lap, tbl[i].smp, tbl[i].pps);
         chk($sformatf("tbl%0d_state", i), 16'(state), 16'(tbl[i].st));
         chk($sformatf("tbl%0d_pulse", i), 16'(pulse_cnt), 16'(tbl[i].pu));
         chk($sformatf("tbl%0d_sft", i), 16'(sft_rst), 16'(tbl[i].sr));
         chk($sformatf("tbl%0d_disp", i), disp_data, tbl[i].disp);
      end

      // lap sequence
      hold(0, 0, 0, DEB);
      hold(1, 0, 0, DEB);
      chk("lap_run", 16'(state), 16'h0001);
      hold(0, 0, 0, DEB);
      live_data = 16'h0123;
      hold(0, 0, 1, DEB);
`ifdef SW_CTRL_LAP_EN
      chk("lap_state", 16'(state), 16'h0003);
      chk("lap_disp", disp_data, 16'h0123);
      live_data = 16'h0130;
      apply(0, 0, 1, 0, 1);
      apply(0, 0, 1, 0, 0);
      chk("lap_count", 16'(pulse_cnt), 16'h0000);
      chk("lap_hold", disp_data, 16'h0123);
      hold(0, 0, 0, DEB);
      hold(0, 0, 1, DEB);
      chk("lap_release", 16'(state), 16'h0001);
      apply(0, 0, 1, 0, 0);
      chk("lap_track", disp_data, 16'h0130);
`else
      chk("nolap_state", 16'(state), 16'h0001);
      live_data = 16'h0130;
      apply(0, 0, 1, 0, 1);
      chk("nolap_disp", disp_data, 16'h0130);
      apply(0, 0, 1, 0, 0);
      chk("nolap_count", 16'(pulse_cnt), 16'h0000);
`endif
      hold(0, 0, 0, DEB);

      // asynchronous reset mid-operation, with ss already held high
      key_ss = 1'b1; key_smp = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 16'(state), 16'h0000);
      chk("arst_disp", disp_data, 16'h0000);
      chk("arst_pulse", 16'(pulse_cnt), 16'h0000);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      hold(1, 0, 0, DEB - 1);
      chk("arst_fresh", 16'(state), 16'h0000);
      hold(1, 0, 0, 1);
      chk("arst_start", 16'(state), 16'h0001);
      hold(1, 0, 0, 6);
      chk("held_once", 16'(state), 16'h0001);

      // random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(9) == 0) key_ss  = ~key_ss;
         if ($urandom_range(14) == 0) key_clr = ~key_clr;
         if ($urandom_range(9) == 0) key_lap = ~key_lap;
         key_smp = ($urandom_range(2) == 0);
         pps     = ($urandom_range(5) == 0);
         if ($urandom_range(3) == 0) live_data = 16'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_ctrl.md
# sw_ctrl

Run/pause/clear/lap controller for the MM:SS stopwatch datapath. Debounces three control keys on the key-filter strobe, runs a 4-state FSM, and drives the gated 1-second increment pulse into the first BCD counter stage. Also drives the soft-reset pulse for all four stages and the 16-bit BCD value presented to the 7-segment display multiplexer. Sits between `pulse_gen` and the `cnt` cascade, replacing direct `keys & pps` gating.

## Interface
- `DEB_CNT`, 3: consecutive identical filter-strobe samples required to accept a key level (1–15).
- `DATA_WIDTH`, 16: width of the BCD display bus (4 digits × 4 bits).

- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `key_smp` in 1: key-filter sample strobe, one `clk` cycle wide.
- `pps` in 1: 1-second pulse, one `clk` cycle wide.
- `key_ss` in 1: start/stop key, raw, active-high.
- `key_clr` in 1: clear key, raw, active-high.
- `key_lap` in 1: lap key, raw, active-high.
- `live_data` in `DATA_WIDTH`: current counter digits, {d3,d2,d1,d0}.
- `pulse_cnt` out 1: increment pulse to counter stage 0.
- `sft_rst` out 1: soft-reset pulse to all counter stages.
- `disp_data` out `DATA_WIDTH`: digits to the display mux.
- `state` out 2: FSM state, also routed to LEDs.

## Operation
- **Debounce.** Per key, a sampler updates only on cycles where `key_smp`=1.
  - Stable level changes after `DEB_CNT` consecutive equal samples that differ from the current stable level.
  - An event is a 0→1 transition of the stable level. It is a single-cycle internal pulse on the `key_smp` cycle that completes the count.
- **Priority.** When several events occur in one cycle, `clr` wins over `ss`, and `ss` wins over `lap`. Lower-priority events in that cycle are discarded.
- **FSM states.** IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - IDLE:
    - `ss` → RUN.
    - `clr` → stays IDLE and issues `sft_rst`.
    - `lap` ignored.
  - RUN:
    - `ss` → PAUSE.
    - `lap` → LAP; latch `live_data` into the lap register.
    - `clr` ignored.
  - PAUSE:
    - `ss` → RUN.
    - `clr` → IDLE and issues `sft_rst`.
    - `lap` ignored.
  - LAP:
    - `lap` → RUN, releasing the freeze.
    - `ss` → PAUSE, releasing the freeze.
    - `clr` ignored.
- **Counting.** `pulse_cnt` follows `pps` only while in RUN or LAP. Counting continues during LAP.
- **Display.**
  - In LAP, `disp_data` = lap register.
  - In all other states, `disp_data` follows `live_data`.
- **Wrap.** The 59:59→00:00 wrap is handled by the counters. The controller takes no action.

## Timing
- **Reset values:**
  - `state`=IDLE.
  - `pulse_cnt`=0, `sft_rst`=0, `disp_data`=0.
  - Lap register=0.
  - Debounce counters=0; stable levels=0.
- **Key to state.** The state register updates on the `clk` edge after the event cycle, i.e. 1 cycle of latency from the completing `key_smp` cycle.
- **`sft_rst`.** Registered; high for exactly 1 cycle, in the same cycle the new state appears.
- **`pulse_cnt`.** Registered; `pulse_cnt[n+1] = pps[n] & (state[n]==RUN || state[n]==LAP)`.
  - A `pps` in the same cycle as an `ss` event that leaves RUN still passes.
  - A `pps` in the same cycle as an `ss` event that enters RUN is blocked.
- **`disp_data`.** Registered, 1-cycle latency from `live_data`. The lap latch captures the `live_data` value present in the event cycle.
- **Reset mid-operation.** Asynchronous assertion forces all reset values immediately. The first event after deassertion requires `DEB_CNT` fresh samples.
- **Held keys.** A key held indefinitely produces exactly one event. Release must itself debounce before the next press counts.

## Configuration
- `SW_CTRL_LAP_EN`:
  - **Defined:** LAP state, lap register and `key_lap` handling are compiled in, as specified above.
  - **Undefined:**
    - `key_lap` is ignored and the lap register is not built.
    - State 2'b11 is unreachable; if ever entered, the FSM returns to IDLE on the next cycle.
    - `disp_data` always follows `live_data`, with 1-cycle latency.

## Test plan
- **Reset:** `rst_n`=0 for 5 cycles, then 1 → `state`=00, `pulse_cnt`=0, `sft_rst`=0, `disp_data`=16'h0000. No event until 3 `key_smp` strobes with a key held.
- **Start:** `key_ss` held high across 3 `key_smp` strobes → `state`=01 one cycle after the 3rd strobe. Subsequent `pps` pulses appear on `pulse_cnt` delayed 1 cycle. Five `pps` pulses → 5 `pulse_cnt` pulses.
- **Bounce:** `key_ss` toggles 1,0,1,0 on consecutive strobes → no state change. Then 3 stable high samples → exactly one transition.
- **Lap:** in RUN with `live_data`=16'h0123, press `lap` → `state`=11 and `disp_data`=16'h0123. `disp_data` holds while `live_data` advances to 16'h0130. Second `lap` press → `disp_data` tracks `live_data` again.
- **Pause/clear:** RUN → `ss` → PAUSE. `pps` then gives no `pulse_cnt`. `clr` → `state`=00 and `sft_rst` high for exactly 1 cycle.
- **Simultaneous:** in PAUSE, `clr` and `ss` complete on the same strobe → IDLE with `sft_rst`=1, not RUN. With `SW_CTRL_LAP_EN` undefined, a `lap` press in RUN → no state change.
